// File: rtl/uart_tx_pkg.sv
// Shared constants for the UART transmit path.
//   - FSM state encodings for uart_tx_ctrl (also visible on its state_dbg port)
//   - Mux select codes decoded by the TX output mux
//   - Parity type codes for PAR_TYP
package uart_tx_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  localparam logic [1:0] SEL_START = 2'b00;
  localparam logic [1:0] SEL_STOP  = 2'b01;
  localparam logic [1:0] SEL_DATA  = 2'b10;
  localparam logic [1:0] SEL_PAR   = 2'b11;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_parity_calc.sv
// Combinational parity generator.
//   data    in  DATA_WIDTH  word to protect
//   par_typ in  1           PAR_EVEN / PAR_ODD
//   parity  out 1           XOR-reduce of data, inverted for odd parity
module uart_parity_calc
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  par_typ,
  output logic                  parity
);

  assign parity = (^data) ^ (par_typ == PAR_ODD);

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer. Serializes a parallel word LSB first by steering
// the select / serial-data / parity inputs of the registered TX output mux.
// One CLK cycle is one bit period.
//   CLK        in  1           bit-rate clock
//   RST        in  1           asynchronous active-low reset
//   P_Data     in  DATA_WIDTH  word to send
//   Data_Valid in  1           send request, only looked at while idle
//   PAR_EN     in  1           append parity bit to this frame
//   PAR_TYP    in  1           PAR_EVEN / PAR_ODD
//   Mux_Sel    out 2           SEL_START / SEL_STOP / SEL_DATA / SEL_PAR
//   Ser_Data   out 1           current data bit (LSB of shift register)
//   Parity     out 1           parity of the frame being sent
//   Busy       out 1           frame in progress
//   state_dbg  out 3           current FSM state (ST_* encoding)
//
// Handshake: a request is accepted on any rising edge where Data_Valid=1 and
// Busy=0; there is no ready/back-pressure, requests seen while Busy=1 are
// dropped, and P_Data/PAR_EN/PAR_TYP are only captured on the accepting edge.
module uart_tx_ctrl
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_Data,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [1:0]            Mux_Sel,
  output logic                  Ser_Data,
  output logic                  Parity,
  output logic                  Busy,
  output logic [2:0]            state_dbg
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  logic [2:0]            state;
  logic [CNT_W-1:0]      bit_cnt;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic                  par_en_q;
  logic                  parity_next;

  // Parity type only matters at accept time: the bit is computed from the
  // incoming word and frozen, so PAR_TYP itself never needs to be stored.
  uart_parity_calc #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_parity (
    .data    (P_Data),
    .par_typ (PAR_TYP),
    .parity  (parity_next)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      shift_reg <= '0;
      par_en_q  <= 1'b0;
      Parity    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (Data_Valid) begin
            shift_reg <= P_Data;
            par_en_q  <= PAR_EN;
            Parity    <= parity_next;
            state     <= ST_START;
          end
        end
        ST_START: begin
          bit_cnt <= '0;
          state   <= ST_DATA;
        end
        ST_DATA: begin
          shift_reg <= shift_reg >> 1;
          // Counter stops at the terminal value instead of wrapping; it is
          // cleared again in START before the next frame.
          if (bit_cnt == CNT_LAST) begin
            state <= par_en_q ? ST_PARITY : ST_STOP;
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end
        ST_PARITY: state <= ST_STOP;
        ST_STOP:   state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  // Moore outputs decoded from the state register only, so Data_Valid never
  // reaches Busy or Mux_Sel combinationally.
  always_comb begin
    Mux_Sel = SEL_STOP;
    case (state)
      ST_START:  Mux_Sel = SEL_START;
      ST_DATA:   Mux_Sel = SEL_DATA;
      ST_PARITY: Mux_Sel = SEL_PAR;
      default:   Mux_Sel = SEL_STOP;
    endcase
  end

  assign Busy      = (state != ST_IDLE);
  assign Ser_Data  = shift_reg[0];
  assign state_dbg = state;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl: drives frames one after another and checks
// select, decoded line bit, parity and busy on every cycle of each frame.
module tb_uart_tx_ctrl;
  import uart_tx_pkg::*;

  logic       CLK;
  logic       RST;
  logic [7:0] P_Data;
  logic       Data_Valid;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [1:0] Mux_Sel;
  logic       Ser_Data;
  logic       Parity;
  logic       Busy;
  logic [2:0] state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  uart_tx_ctrl #(.DATA_WIDTH(8)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_Data     (P_Data),
    .Data_Valid (Data_Valid),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .Mux_Sel    (Mux_Sel),
    .Ser_Data   (Ser_Data),
    .Parity     (Parity),
    .Busy       (Busy),
    .state_dbg  (state_dbg)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Bit the mux will put on the line one cycle later.
  function automatic logic line_bit();
    case (Mux_Sel)
      SEL_START: return 1'b0;
      SEL_STOP:  return 1'b1;
      SEL_DATA:  return Ser_Data;
      default:   return Parity;
    endcase
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Present a request during an idle cycle; returns in the START cycle.
  task automatic launch(input logic [7:0] d, input logic pe, input logic pt);
    P_Data     = d;
    PAR_EN     = pe;
    PAR_TYP    = pt;
    Data_Valid = 1'b1;
    step();
    Data_Valid = 1'b0;
  endtask

  // Called in the START cycle. Checks every cycle of the frame, applies the
  // mid-frame disturbances at data bit 3, and returns in the cycle after STOP.
  task automatic check_frame(input string name, input logic [7:0] d, input logic pe,
                             input logic par, input logic [7:0] d_mid, input logic pe_mid,
                             input logic dv_mid, input logic dv_after);
    int len;
    logic [1:0] exp_sel;
    logic       exp_bit;
    len = 10 + int'(pe);
    for (int i = 0; i < len; i++) begin
      if (i == 0) begin
        exp_sel = SEL_START; exp_bit = 1'b0;
        check({name, " state_start"}, 8'(state_dbg), 8'(ST_START));
      end else if (i <= 8) begin
        exp_sel = SEL_DATA;  exp_bit = d[i-1];
      end else if (i == 9 && pe) begin
        exp_sel = SEL_PAR;   exp_bit = par;
      end else begin
        exp_sel = SEL_STOP;  exp_bit = 1'b1;
      end
      check($sformatf("%s sel[%0d]", name, i),  8'(Mux_Sel), 8'(exp_sel));
      check($sformatf("%s bit[%0d]", name, i),  8'(line_bit()), 8'(exp_bit));
      check($sformatf("%s busy[%0d]", name, i), 8'(Busy), 8'h01);
      check($sformatf("%s par[%0d]", name, i),  8'(Parity), 8'(par));
      if (i == 4) begin
        P_Data     = d_mid;
        PAR_EN     = pe_mid;
        Data_Valid = dv_mid;
      end
      if (i == 5) Data_Valid = dv_after;
      step();
    end
    check({name, " idle_busy"}, 8'(Busy), 8'h00);
    check({name, " idle_sel"},  8'(Mux_Sel), 8'(SEL_STOP));
  endtask

  initial begin
    RST = 1'b0; P_Data = 8'h00; Data_Valid = 1'b0; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    #12;
    check("rst busy",   8'(Busy), 8'h00);
    check("rst sel",    8'(Mux_Sel), 8'(SEL_STOP));
    check("rst ser",    8'(Ser_Data), 8'h00);
    check("rst parity", 8'(Parity), 8'h00);
    check("rst state",  8'(state_dbg), 8'(ST_IDLE));
    RST = 1'b1;
    step();
    step();
    check("idle hold busy", 8'(Busy), 8'h00);

    // A5 even parity -> parity 0; a mid-frame Data_Valid pulse must be ignored.
    launch(8'hA5, 1'b1, PAR_EVEN);
    check_frame("a5_even", 8'hA5, 1'b1, 1'b0, 8'h12, 1'b1, 1'b1, 1'b0);

    // A5 odd parity -> parity 1.
    launch(8'hA5, 1'b1, PAR_ODD);
    check_frame("a5_odd", 8'hA5, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0);

    // 3C without parity: 10-cycle frame, never SEL_PAR.
    launch(8'h3C, 1'b0, PAR_EVEN);
    check_frame("3c_nopar", 8'h3C, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0);

    // Data_Valid held high: FF frame, P_Data switched to 00 mid-frame, then
    // exactly one idle cycle and the 00 frame starts.
    P_Data = 8'hFF; PAR_EN = 1'b0; PAR_TYP = PAR_EVEN; Data_Valid = 1'b1;
    step();
    check_frame("b2b_ff", 8'hFF, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    step();
    check("b2b restart busy", 8'(Busy), 8'h01);
    check_frame("b2b_00", 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    // Reset during data bit 3 (START + 4 cycles).
    launch(8'h5A, 1'b1, PAR_ODD);
    repeat (4) step();
    check("pre_rst sel", 8'(Mux_Sel), 8'(SEL_DATA));
    #2;
    RST = 1'b0;
    #1;
    check("mid_rst busy",   8'(Busy), 8'h00);
    check("mid_rst sel",    8'(Mux_Sel), 8'(SEL_STOP));
    check("mid_rst parity", 8'(Parity), 8'h00);
    check("mid_rst state",  8'(state_dbg), 8'(ST_IDLE));
    step();
    RST = 1'b1;
    step();
    check("post_rst busy", 8'(Busy), 8'h00);
    launch(8'h81, 1'b1, PAR_EVEN);
    check_frame("81_after_rst", 8'h81, 1'b1, 1'b0, 8'h81, 1'b1, 1'b0, 1'b0);

    // PAR_EN dropped mid-frame: this frame keeps parity (96 odd -> 1),
    // the next one (PAR_EN now 0) omits it.
    launch(8'h96, 1'b1, PAR_ODD);
    check_frame("96_pe_drop", 8'h96, 1'b1, 1'b1, 8'h96, 1'b0, 1'b0, 1'b0);
    launch(8'h96, PAR_EN, PAR_ODD);
    check_frame("96_nopar", 8'h96, 1'b0, 1'b1, 8'h96, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Safety net against a stuck simulation.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
